// File: rtl/int_to_fp_converter.sv
// Sequential 32-bit integer to IEEE 754 single-precision converter.
// Normalizes one bit per cycle, rounds to nearest-even, and uses valid/ready on both sides.
module int_to_fp_converter #(
  parameter int unsigned BIAS      = 127,
  parameter int unsigned INT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WIDTH-1:0] in_data,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_inexact,
  output logic                 busy
);

  // The exponent starts at the value for a magnitude whose MSB is already set.
  localparam logic [7:0] ExpStart = 8'(BIAS + INT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [INT_WIDTH-1:0]   mag_q, mag_d;
  logic [7:0]             exp_q, exp_d;
  logic [31:0]            out_data_q, out_data_d;
  logic                   inexact_q, inexact_d;

  logic                   in_neg;
  logic [INT_WIDTH-1:0]   in_mag;
  logic [22:0]            frac;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [23:0]            frac_sum;
  logic [7:0]             rnd_exp;

  // Sign and magnitude of the presented integer; -2^31 maps to 0x80000000 unchanged.
  always_comb begin
    in_neg = in_signed & in_data[INT_WIDTH-1];
    in_mag = in_neg ? (~in_data + 1'b1) : in_data;
  end

  // Round-to-nearest-even on the normalized magnitude; a mantissa carry bumps the exponent.
  always_comb begin
    frac     = mag_q[30:8];
    guard    = mag_q[7];
    sticky   = |mag_q[6:0];
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + 24'(round_up);
    rnd_exp  = exp_q + 8'(frac_sum[23]);
  end

  // Next-state and datapath updates for the conversion sequence.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    out_data_d = out_data_q;
    inexact_d  = inexact_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_neg;
          mag_d  = in_mag;
          exp_d  = ExpStart;
          if (in_mag == '0) begin
            // Zero is always +0 and skips normalization entirely.
            sign_d     = 1'b0;
            out_data_d = 32'h0000_0000;
            inexact_d  = 1'b0;
            state_d    = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mag_q[INT_WIDTH-1]) begin
          state_d = StRound;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: begin
        out_data_d = {sign_q, rnd_exp, frac_sum[22:0]};
        inexact_d  = guard | sticky;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_q      <= '0;
      out_data_q <= '0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      out_data_q <= out_data_d;
      inexact_q  <= inexact_d;
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    busy        = (state_q != StIdle);
    out_data    = out_data_q;
    out_inexact = inexact_q;
  end

endmodule
